// File: rtl/dataacq_pkg.sv
// Shared constants and helpers for the data-acquisition decimation path.
package dataacq_pkg;

  localparam int DATA_W  = 12;
  localparam int PRESC_W = 7;
  localparam int SUM_W   = DATA_W + PRESC_W;
  localparam int OVR_W   = 8;

  // A prescaler value of zero is treated as "no decimation" (factor 1).
  function automatic logic [PRESC_W-1:0] eff_n(input logic [PRESC_W-1:0] p);
    return (p == '0) ? PRESC_W'(1) : p;
  endfunction

endpackage

// File: rtl/decim_frame_counter.sv
// Frame sequencing for the sample decimator: latches the decimation factor
// at each frame start, counts accepted samples and flags the last one.
// sync_clr restarts the frame; a sample arriving with it becomes sample 0.
module decim_frame_counter
  import dataacq_pkg::*;
(
  input  logic               SYS_CLK,
  input  logic               RESET_N,
  input  logic [PRESC_W-1:0] prescaler_value,
  input  logic               sync_clr,
  input  logic               in_valid,
  output logic               frame_start,
  output logic               frame_done,
  output logic               frame_busy
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] n_lat;
  logic [PRESC_W-1:0] n_cur;
  logic [PRESC_W-1:0] cnt_cur;

  // Decode frame boundaries; at frame start the fresh factor applies immediately.
  always_comb begin
    frame_start = in_valid && (sync_clr || (cnt == '0));
    n_cur       = frame_start ? eff_n(prescaler_value) : n_lat;
    cnt_cur     = frame_start ? '0 : cnt;
    frame_done  = in_valid && (cnt_cur == (n_cur - PRESC_W'(1)));
  end

  assign frame_busy = (cnt != '0);

  // Sample counter and factor latch.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt   <= '0;
      n_lat <= PRESC_W'(1);
    end else begin
      if (in_valid) begin
        cnt <= frame_done ? '0 : (cnt_cur + PRESC_W'(1));
      end else if (sync_clr) begin
        cnt <= '0;
      end
      if (frame_start) begin
        n_lat <= n_cur;
      end
    end
  end

endmodule

// File: rtl/sample_decimator.sv
// Decimates the ADC sample stream by the prescaler factor and presents one
// result per frame on a valid/ready output; overwriting an unconsumed result
// pulses overrun and bumps a saturating counter.
// Build option SAMPLE_DECIM_ACCUM_EN: result is the sum of the frame samples;
// otherwise the result is the last sample of the frame (no accumulator).
module sample_decimator
  import dataacq_pkg::*;
(
  input  logic               SYS_CLK,
  input  logic               RESET_N,
  input  logic [PRESC_W-1:0] prescaler_value,
  input  logic               sync_clr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [SUM_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  output logic [OVR_W-1:0]   overrun_cnt,
  output logic               frame_busy
);

  logic             frame_start;
  logic             frame_done;
  logic [SUM_W-1:0] sample_ext;
  logic [SUM_W-1:0] result;

  decim_frame_counter u_frame_counter (
    .SYS_CLK         (SYS_CLK),
    .RESET_N         (RESET_N),
    .prescaler_value (prescaler_value),
    .sync_clr        (sync_clr),
    .in_valid        (in_valid),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .frame_busy      (frame_busy)
  );

  assign sample_ext = SUM_W'(in_data);

`ifdef SAMPLE_DECIM_ACCUM_EN
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_base;

  // The first sample of a frame starts from zero rather than the stale sum.
  assign acc_base = frame_start ? '0 : acc;
  assign result   = acc_base + sample_ext;

  // Running sum of the current frame.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= result;
    end else if (sync_clr) begin
      acc <= '0;
    end
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign result             = sample_ext;
`endif

  // Output register, handshake and overrun tracking.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        out_data  <= result;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
          if (overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + OVR_W'(1);
          end
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
// Self-checking bench for sample_decimator against a frame-level reference
// model (queue of the current frame's samples).
module tb_sample_decimator;
  import dataacq_pkg::*;

  logic               sys_clk = 1'b0;
  logic               reset_n;
  logic [PRESC_W-1:0] prescaler_value;
  logic               sync_clr;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic [SUM_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic [OVR_W-1:0]   overrun_cnt;
  logic               frame_busy;

  always #5 sys_clk = ~sys_clk;

  sample_decimator dut (
    .SYS_CLK         (sys_clk),
    .RESET_N         (reset_n),
    .prescaler_value (prescaler_value),
    .sync_clr        (sync_clr),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .overrun         (overrun),
    .overrun_cnt     (overrun_cnt),
    .frame_busy      (frame_busy)
  );

  int errors = 0;
  int checks = 0;
  int handoffs = 0;

  // Reference model state
  int unsigned frame_q[$];
  int          m_n;
  longint      m_data;
  bit          m_valid;
  bit          m_ovr;
  int          m_ovr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_n       = 1;
    m_data    = 0;
    m_valid   = 0;
    m_ovr     = 0;
    m_ovr_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input int unsigned d, input bit rdy,
                            input int p, input bit clr);
    bit     done = 0;
    longint res  = 0;
    m_ovr = 0;
    if (v) begin
      if (clr || frame_q.size() == 0) begin
        frame_q.delete();
        m_n = (p == 0) ? 1 : p;
      end
      frame_q.push_back(d);
      if (frame_q.size() == m_n) begin
`ifdef SAMPLE_DECIM_ACCUM_EN
        foreach (frame_q[i]) res += frame_q[i];
`else
        res = d;
`endif
        done = 1;
        frame_q.delete();
      end
    end else if (clr) begin
      frame_q.delete();
    end
    if (done) begin
      if (m_valid && !rdy) begin
        m_ovr = 1;
        if (m_ovr_cnt < 255) m_ovr_cnt++;
      end
      m_data  = res;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".overrun_cnt"}, 32'(overrun_cnt), 32'(m_ovr_cnt));
    chk({tag, ".frame_busy"}, 32'(frame_busy), 32'(frame_q.size() != 0));
    if (out_valid === 1'b1 && out_ready === 1'b1) handoffs++;
  endtask

  // One clock: drive at negedge, let the edge happen, check at the next negedge.
  task automatic step(input string tag, input bit v, input int unsigned d,
                      input bit rdy, input int p, input bit clr);
    in_valid        = v;
    in_data         = DATA_W'(d);
    out_ready       = rdy;
    prescaler_value = PRESC_W'(p);
    sync_clr        = clr;
    @(posedge sys_clk);
    model_edge(v, d, rdy, p, clr);
    @(negedge sys_clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 0; sync_clr = 0; out_ready = 0; in_data = '0; prescaler_value = '0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_outputs("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // N=5, ten back-to-back samples, ready high: two results
    handoffs = 0;
    for (int i = 0; i < 10; i++) step("n5", 1, $urandom_range(0, 4095), 1, 5, 0);
    step("n5_idle", 0, 0, 1, 5, 0);
    chk("n5_results", 32'(handoffs), 32'd2);

    // N=4, samples 1..4
    for (int i = 1; i <= 4; i++) step("n4", 1, i, 1, 4, 0);
`ifdef SAMPLE_DECIM_ACCUM_EN
    chk("n4_value", 32'(out_data), 32'd10);
`else
    chk("n4_value", 32'(out_data), 32'd4);
`endif
    step("n4_idle", 0, 0, 1, 4, 0);

    // N=1 and prescaler 0 each give one result per sample
    for (int i = 0; i < 4; i++) step("n1", 1, $urandom_range(0, 4095), 1, 1, 0);
    for (int i = 0; i < 4; i++) step("n0", 1, $urandom_range(0, 4095), 1, 0, 0);
    step("n0_idle", 0, 0, 1, 0, 0);

    // Stalled output, N=2, six samples: two overruns
    do_reset();
    for (int i = 0; i < 6; i++) step("ovr", 1, 100 + i, 0, 2, 0);
    chk("ovr_count", 32'(overrun_cnt), 32'd2);
`ifdef SAMPLE_DECIM_ACCUM_EN
    chk("ovr_last", 32'(out_data), 32'd209);
`else
    chk("ovr_last", 32'(out_data), 32'd105);
`endif

    // Long stall saturates the counter
    for (int i = 0; i < 300; i++) step("sat", 1, $urandom_range(0, 4095), 0, 1, 0);
    chk("sat_count", 32'(overrun_cnt), 32'd255);
    step("sat_drain", 0, 0, 1, 1, 0);

    // Factor change mid-frame only applies at the next frame
    for (int i = 0; i < 3; i++) step("sw10", 1, $urandom_range(0, 4095), 1, 10, 0);
    for (int i = 0; i < 27; i++) step("sw20", 1, $urandom_range(0, 4095), 1, 20, 0);

    // sync_clr with a sample restarts the frame at that sample
    do_reset();
    for (int i = 0; i < 3; i++) step("clr_pre", 1, $urandom_range(0, 4095), 1, 5, 0);
    step("clr", 1, $urandom_range(0, 4095), 1, 5, 1);
    for (int i = 0; i < 4; i++) step("clr_post", 1, $urandom_range(0, 4095), 1, 5, 0);
    chk("clr_idle_busy", 32'(frame_busy), 32'd0);
    step("clr_only", 0, 0, 1, 5, 1);

    // Reset in the middle of a frame with a pending result
    for (int i = 0; i < 3; i++) step("mid", 1, $urandom_range(1, 4095), 0, 2, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 4095),
           ($urandom_range(0, 2) != 0),
           $urandom_range(0, 7),
           ($urandom_range(0, 40) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
